// File: rtl/pma_rx_descrambler.sv
// rtl/pma_rx_descrambler.sv - 100BASE-TX receive descrambler with idle-run lock and hold timer
// Trains the x^11+x^9+1 key from scrambled idle, then free-runs it while LOCKED.
module pma_rx_descrambler #(
    parameter int LOCK_IDLE   = 25,
    parameter int HOLD_IDLE   = 60,
    parameter int HOLD_CYCLES = 90250,
    localparam int TW         = $clog2(HOLD_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       signal_detect,
    input  logic [1:0] bits,
    input  logic [1:0] bits_valid,
    output logic [1:0] data,
    output logic [1:0] data_valid,
    output logic       locked
);

    typedef enum logic {UNLOCKED, LOCKED} state_t;

    localparam logic [TW-1:0] HOLD_RELOAD = TW'(HOLD_CYCLES);
    localparam logic [5:0]    LOCK_RUN    = 6'(LOCK_IDLE);
    localparam logic [5:0]    HOLD_RUN    = 6'(HOLD_IDLE);

    state_t        state;
    logic [10:0]   lfsr;
    logic [5:0]    run;
    logic [TW-1:0] timer;

    logic          free_run;
    logic          k1, k2, p1, p2, fb1, fb2;
    logic [10:0]   lfsr1, lfsr2, lfsr_next;
    logic [5:0]    run1, run2, run_next;
    logic          lock_entry, reload, plain_out;
    logic [1:0]    data_next;

    function automatic logic [5:0] run_step(input logic [5:0] r, input logic p);
        if (!p) begin
            return 6'd0;
        end
        return (r == 6'd63) ? r : r + 6'd1;
    endfunction

    always_comb begin
        // Key is only trusted (self-clocked) while locked with the PMD reporting signal.
        free_run = (state == LOCKED) && signal_detect;

        k1    = lfsr[10] ^ lfsr[8];
        p1    = bits[1] ^ k1;
        fb1   = free_run ? k1 : ~bits[1];
        lfsr1 = {lfsr[9:0], fb1};

        k2    = lfsr1[10] ^ lfsr1[8];
        p2    = bits[0] ^ k2;
        fb2   = free_run ? k2 : ~bits[0];
        lfsr2 = {lfsr1[9:0], fb2};

        run1 = run_step(run, p1);
        run2 = run_step(run1, p2);

        case (bits_valid)
            2'd1: begin
                lfsr_next = lfsr1;
                run_next  = run1;
            end
            2'd2: begin
                lfsr_next = lfsr2;
                run_next  = run2;
            end
            default: begin
                lfsr_next = lfsr;
                run_next  = run;
            end
        endcase

        lock_entry = (state == UNLOCKED) && signal_detect && (run_next >= LOCK_RUN);
        reload     = (state == LOCKED) && signal_detect && (run_next >= HOLD_RUN);
        plain_out  = (state == LOCKED) || lock_entry;

        // Unused and invalid positions read as idle so the PCS never sees false carrier.
        data_next = 2'b11;
        if (plain_out) begin
            if (bits_valid != 2'd0) begin
                data_next[1] = p1;
            end
            if (bits_valid == 2'd2) begin
                data_next[0] = p2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            lfsr       <= 11'h7FF;
            run        <= 6'd0;
            timer      <= HOLD_RELOAD;
            data       <= 2'b11;
            data_valid <= 2'd0;
            locked     <= 1'b0;
        end else begin
            lfsr       <= lfsr_next;
            data       <= data_next;
            data_valid <= bits_valid;
            if (!signal_detect) begin
                state  <= UNLOCKED;
                run    <= 6'd0;
                timer  <= HOLD_RELOAD;
                locked <= 1'b0;
            end else if (state == UNLOCKED) begin
                run <= run_next;
                if (lock_entry) begin
                    state  <= LOCKED;
                    timer  <= HOLD_RELOAD;
                    locked <= 1'b1;
                end
            end else if (reload) begin
                run   <= run_next;
                timer <= HOLD_RELOAD;
            end else if (timer == '0) begin
                state  <= UNLOCKED;
                run    <= 6'd0;
                locked <= 1'b0;
            end else begin
                run   <= run_next;
                timer <= timer - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pma_rx_descrambler.sv
// tb/tb_pma_rx_descrambler.sv - directed bench for pma_rx_descrambler
// A reference x^11+x^9+1 scrambler feeds known plaintext; outputs are compared to that plaintext.
module tb_pma_rx_descrambler;

    localparam int LOCK_IDLE   = 25;
    localparam int HOLD_IDLE   = 60;
    localparam int HOLD_CYCLES = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       signal_detect = 1'b0;
    logic [1:0] bits = 2'b00;
    logic [1:0] bits_valid = 2'd0;
    logic [1:0] data;
    logic [1:0] data_valid;
    logic       locked;

    logic [10:0] scr;
    logic [29:0] frame;
    logic [11:0] jk;
    logic [1:0]  p;
    logic [1:0]  v;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lock1, cyc, nbits, bits3, idx;
    int          pat [5] = '{2, 1, 0, 2, 1};

    pma_rx_descrambler #(
        .LOCK_IDLE  (LOCK_IDLE),
        .HOLD_IDLE  (HOLD_IDLE),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_detect(signal_detect),
        .bits         (bits),
        .bits_valid   (bits_valid),
        .data         (data),
        .data_valid   (data_valid),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic scr_bit(input logic pb, output logic b);
        logic k;
        k   = scr[10] ^ scr[8];
        scr = {scr[9:0], k};
        b   = pb ^ k;
    endtask

    // Drive one cycle of input, then sample just after the capturing edge.
    task automatic send(input logic [1:0] plain, input logic [1:0] nv);
        logic b1, b0;
        b1 = 1'($urandom_range(0, 1));
        b0 = 1'($urandom_range(0, 1));
        if (nv != 2'd0) scr_bit(plain[1], b1);
        if (nv == 2'd2) scr_bit(plain[0], b0);
        bits       = {b1, b0};
        bits_valid = nv;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_run(input int n);
        for (int c = 0; c < n; c++) begin
            send(2'b11, 2'd2);
            check_eq("idle_out", 32'({locked, data_valid, data}), 32'(5'b1_10_11));
        end
    endtask

    task automatic acquire(input int limit, output int at);
        at = 0;
        for (int c = 1; c <= limit && at == 0; c++) begin
            send(2'b11, 2'd2);
            if (locked) at = c;
        end
    endtask

    initial begin
        // Reset values
        signal_detect = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_data", 32'(data), 32'd3);
        check_eq("rst_valid", 32'(data_valid), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);

        // Initial acquisition on clean scrambled idle
        rst_n = 1'b1;
        scr   = 11'h5A5;
        lock1 = 0;
        for (int c = 1; c <= 19 && lock1 == 0; c++) begin
            send(2'b11, 2'd2);
            check_eq("acq_data", 32'(data), 32'd3);
            if (locked) lock1 = c;
        end
        check_eq("acq_locked_by_19", 32'(locked), 32'd1);
        check_eq("acq_not_early", 32'(lock1 >= 13), 32'd1);
        idle_run(35);

        // /J/K/ 5 D /T/R/ reproduced bit-exact
        frame = 30'b11000_10001_01011_11011_01101_00111;
        for (int i = 29; i >= 1; i -= 2) begin
            send({frame[i], frame[i-1]}, 2'd2);
            check_eq("frame_data", 32'(data), 32'({frame[i], frame[i-1]}));
        end
        idle_run(35);

        // One-cycle signal_detect drop; relock needs 25 fresh idle bits = 13 cycles
        signal_detect = 1'b0;
        send(2'b11, 2'd2);
        check_eq("sd_drop_locked", 32'(locked), 32'd0);
        signal_detect = 1'b1;
        acquire(30, cyc);
        check_eq("sd_relock_cycles", 32'(cyc), 32'd13);
        idle_run(35);

        // Hold timer: last reload on the final idle cycle, unlock on the 101st data edge
        for (int c = 1; c <= 100; c++) send(2'b00, 2'd2);
        check_eq("hold_still_locked", 32'(locked), 32'd1);
        check_eq("hold_data_plain", 32'(data), 32'd0);
        send(2'b00, 2'd2);
        check_eq("hold_unlock_101", 32'(locked), 32'd0);
        send(2'b00, 2'd2);
        check_eq("hold_data_forced", 32'(data), 32'd3);
        acquire(30, cyc);
        check_eq("hold_relock_window", 32'(cyc >= 13 && cyc <= 18), 32'd1);
        idle_run(5);

        // Asynchronous reset in the middle of a packet
        for (int i = 29; i >= 20; i -= 2) send({frame[i], frame[i-1]}, 2'd2);
        check_eq("pkt_locked", 32'(locked), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_locked", 32'(locked), 32'd0);
        check_eq("arst_data", 32'(data), 32'd3);
        check_eq("arst_valid", 32'(data_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        scr   = 11'h5A5;
        acquire(19, cyc);
        check_eq("arst_reacquire", 32'(cyc), 32'(lock1));

        // Mixed bits_valid 2,1,0,2,1: lock after the same number of valid bits
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        scr   = 11'h5A5;
        nbits = 0;
        bits3 = 0;
        for (int c = 0; c < 60 && bits3 == 0; c++) begin
            v = 2'(pat[c % 5]);
            send(2'b11, v);
            nbits += int'(v);
            check_eq("mix_valid_mirror", 32'(data_valid), 32'(v));
            if (locked) bits3 = nbits;
        end
        check_eq("mix_locked", 32'(locked), 32'd1);
        check_eq("mix_lock_bits", 32'(bits3 >= 2*lock1-1 && bits3 <= 2*lock1+1), 32'd1);

        jk  = 12'b1100_0100_0111;
        idx = 11;
        for (int c = 0; c < 10; c++) begin
            v = 2'(pat[c % 5]);
            p = 2'b11;
            if (v != 2'd0) begin
                p[1] = jk[idx];
                idx--;
            end
            if (v == 2'd2) begin
                p[0] = jk[idx];
                idx--;
            end
            send(p, v);
            check_eq("mix_jk_data", 32'(data), 32'(p));
            check_eq("mix_jk_valid", 32'(data_valid), 32'(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pma_rx_descrambler.md
# pma_rx_descrambler

Receive-side descrambler for 100BASE-TX. It sits between the PMD bit recovery and the PCS receive process. It recovers the x^11+x^9+1 scrambler key from received scrambled idle, locks to it, and passes descrambled bits downstream with the same bits/bits_valid convention the PCS consumes. It also supplies a `locked` indication that the link-monitor logic ANDs into `link_status`.

## Interface
- LOCK_IDLE, 25: consecutive descrambled 1s required to enter LOCKED.
- HOLD_IDLE, 60: consecutive descrambled 1s that reload the hold timer while LOCKED.
- HOLD_CYCLES, 90250: hold-timer reload value in clk cycles (722 µs at 125 MHz). Its width is clog2(HOLD_CYCLES+1).

Ports:
- clk  in  1  receive clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- signal_detect  in  1  PMD signal detect; low forces UNLOCKED.
- bits  in  2  scrambled input bits; bits[1] is the oldest.
- bits_valid  in  2  number of valid input bits (0, 1 or 2). If 1, only bits[1] is valid. The value 3 never occurs.
- data  out  2  descrambled bits; data[1] is the oldest.
- data_valid  out  2  registered copy of bits_valid.
- locked  out  1  high while in the LOCKED state.

## Operation
- The LFSR `s[10:0]` generates the key bit `k = s[10] ^ s[8]`. Each processed bit shifts the LFSR left by one; the new bit enters `s[0]`.
- Bits are processed serially within a cycle: first bits[1], then bits[0] if bits_valid==2. With bits_valid==0, the LFSR, counter and timer hold, except that the timer still decrements.
- Per bit:
  - Plain bit `p = b ^ k`.
  - UNLOCKED: shift in `~b`, since idle plaintext is 1 and so key = ~scrambled.
  - LOCKED: shift in `k` (free-running).
- Idle counter `run`, 6 bits, saturating at 63. Per bit, `run = p ? run+1 : 0`. Evaluate `run_next` after both bits.
- State machine:
  - UNLOCKED → LOCKED when `run_next >= LOCK_IDLE` and signal_detect is high. On entry, `timer <= HOLD_CYCLES`.
  - LOCKED:
    - `timer <= HOLD_CYCLES` when `run_next >= HOLD_IDLE`.
    - Otherwise, if timer==0 → UNLOCKED with `run <= 0`.
    - Otherwise, `timer <= timer-1`.
  - In any state, signal_detect low → UNLOCKED, `run <= 0`, `timer <= HOLD_CYCLES`. The LFSR continues shifting in `~b`.
- Output data:
  - LOCKED (in the state sampled this cycle, or entering it this cycle): the plain bits, with invalid positions driven to 1.
  - UNLOCKED: `2'b11`, so the PCS sees idle and never detects a false carrier from garbage.
- Simultaneous events: signal_detect low has priority over the lock transition and over a timer reload. A reload has priority over timer expiry in the same cycle.

## Timing
- One-cycle latency: data and data_valid are registered from the bits and bits_valid of the previous cycle. `locked` updates on the same edge as the data it qualifies.
- Reset values:
  - Internal: s=11'h7FF, run=0, timer=HOLD_CYCLES, state UNLOCKED.
  - Outputs: data=2'b11, data_valid=0, locked=0.
- Reset is asynchronous in both directions. Reset mid-LOCKED drops `locked` and forces data to 11 immediately. The first post-reset edge behaves as from power-up.
- Lock latency on clean scrambled idle at 2 bits/cycle is at most 11 fill bits plus LOCK_IDLE matches, i.e. ≤18 cycles of input plus 1 output register. Chance matches may lock earlier, but a locked state is never entered with run < LOCK_IDLE.
- Unlock after loss of idle occurs exactly HOLD_CYCLES+1 edges after the last reload.

## Test plan
- Reset, then feed scrambled idle (plain all 1s, scrambler seed 11'h5A5) at bits_valid=2 → locked rises by edge 19, and data==2'b11 with data_valid==2 thereafter.
- After lock, scramble the PCS stream /J/K/ then nibbles 0x5,0xD, then /T/R/ (codes 11000 10001 01011 11011 01101 00111) → data reproduces those code groups bit-exact, one cycle delayed.
- Mixed bits_valid pattern 2,1,0,2,1 on the same idle stream → lock reached after the same number of valid bits. The bits_valid=0 cycles leave run and LFSR unchanged, and data_valid mirrors the pattern.
- With HOLD_CYCLES=100, lock, then send continuous scrambled data with no 60-bit idle run → locked falls exactly 101 edges after the last reload, data forced to 11, run=0.
- Drop signal_detect for 1 cycle while LOCKED → locked low on the next edge. Relock takes ≥LOCK_IDLE bits after signal_detect returns.
- Assert rst_n low mid-packet while LOCKED → locked=0, data=11 and data_valid=0 asynchronously, before the next edge. After release, lock reacquires as in the first scenario.
